// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the data-memory access path:
// funct3 width codes, LSU FSM states and LSU fault causes.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10,
        LSU_DONE = 2'b11
    } lsu_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_ILLEGAL  = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } lsu_fault_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access shaping: store strobes/replication, load extract and
// extension, and legality checks for the request presented in IDLE.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data,
    output lsu_fault_t  o_fault
);

    logic       w_illegal;
    logic       w_misalign;
    logic [3:0] w_strb;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_illegal  = i_we ? (i_funct3 >= 3'b011)
                          : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
        // funct3[1:0] gives the access size for both signed and unsigned loads
        w_misalign = (i_funct3[1:0] == 2'b01 && i_off[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_off != 2'b00);
        if (w_illegal)       o_fault = FLT_ILLEGAL;
        else if (w_misalign) o_fault = FLT_MISALIGN;
        else                 o_fault = FLT_NONE;
    end

    always_comb begin
        w_strb  = 4'b0000;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << {i_off[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            2'b10: w_strb = 4'b1111;
            default: w_strb = 4'b0000;
        endcase
        o_wstrb = i_we ? w_strb : 4'b0000;
    end

    always_comb begin
        w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
        w_half = i_rdata[{i_ld_off[1], 4'b0000} +: 16];
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_ld_data = i_rdata;
            F3_LBU:  o_ld_data = {24'd0, w_byte};
            F3_LHU:  o_ld_data = {16'd0, w_half};
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Stage-3 load/store unit: one valid/ready + rvalid bus transaction per access,
// pipeline stall while in flight, fault reporting and aligned load write-back.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_l3,
    input  logic        we_l3,
    input  logic [2:0]  funct3_l3,
    input  logic [31:0] alu_q_l3,
    input  logic [31:0] xrs2_l3,
    output logic [31:0] ram_rdata_l3,
    output logic        stall_l3,
    output logic        fault_l3,
    output logic [1:0]  fault_cause_l3,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_ld_f3;
    logic [1:0]        r_ld_off;

    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ld_data;
    lsu_fault_t        w_fault;
    logic              w_cnt_max;

    lsu_align u_align (
        .i_we        (we_l3),
        .i_funct3    (funct3_l3),
        .i_off       (alu_q_l3[1:0]),
        .i_wdata     (xrs2_l3),
        .i_ld_funct3 (r_ld_f3),
        .i_ld_off    (r_ld_off),
        .i_rdata     (bus_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_ld_data   (w_ld_data),
        .o_fault     (w_fault)
    );

    // Counter starts at 0 on state entry, so the last allowed cycle is TIMEOUT_CYC-1
    assign w_cnt_max = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign stall_l3  = mem_req_l3 && (r_state != LSU_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= LSU_IDLE;
            r_cnt          <= '0;
            r_ld_f3        <= 3'd0;
            r_ld_off       <= 2'd0;
            ram_rdata_l3   <= 32'd0;
            fault_l3       <= 1'b0;
            fault_cause_l3 <= FLT_NONE;
            bus_valid      <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'd0;
            bus_wdata      <= 32'd0;
            bus_wstrb      <= 4'd0;
        end else begin
            fault_l3       <= 1'b0;
            fault_cause_l3 <= FLT_NONE;
            case (r_state)
                LSU_IDLE: begin
                    if (mem_req_l3) begin
                        if (w_fault != FLT_NONE) begin
                            r_state        <= LSU_DONE;
                            fault_l3       <= 1'b1;
                            fault_cause_l3 <= w_fault;
                            ram_rdata_l3   <= 32'd0;
                        end else begin
                            r_state   <= LSU_REQ;
                            r_cnt     <= '0;
                            r_ld_f3   <= funct3_l3;
                            r_ld_off  <= alu_q_l3[1:0];
                            bus_valid <= 1'b1;
                            bus_we    <= we_l3;
                            bus_addr  <= {alu_q_l3[31:2], 2'b00};
                            bus_wdata <= w_wdata;
                            bus_wstrb <= w_wstrb;
                        end
                    end
                end
                LSU_REQ: begin
                    if (bus_ready) begin
                        r_state   <= LSU_RESP;
                        r_cnt     <= '0;
                        bus_valid <= 1'b0;
                    end else if (w_cnt_max) begin
                        r_state        <= LSU_DONE;
                        bus_valid      <= 1'b0;
                        fault_l3       <= 1'b1;
                        fault_cause_l3 <= FLT_TIMEOUT;
                        ram_rdata_l3   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LSU_RESP: begin
                    if (bus_rvalid) begin
                        r_state      <= LSU_DONE;
                        ram_rdata_l3 <= bus_we ? 32'd0 : w_ld_data;
                    end else if (w_cnt_max) begin
                        r_state        <= LSU_DONE;
                        fault_l3       <= 1'b1;
                        fault_cause_l3 <= FLT_TIMEOUT;
                        ram_rdata_l3   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit: a driver plays pipeline and memory,
// a negedge monitor checks bus requests and access results against a model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_l3, we_l3;
    logic [2:0]  funct3_l3;
    logic [31:0] alu_q_l3, xrs2_l3;
    logic [31:0] ram_rdata_l3;
    logic        stall_l3, fault_l3;
    logic [1:0]  fault_cause_l3;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .mem_req_l3(mem_req_l3), .we_l3(we_l3),
        .funct3_l3(funct3_l3), .alu_q_l3(alu_q_l3), .xrs2_l3(xrs2_l3),
        .ram_rdata_l3(ram_rdata_l3), .stall_l3(stall_l3), .fault_l3(fault_l3),
        .fault_cause_l3(fault_cause_l3), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] rdata;
        int          stall;
        bit          chk_stall;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the access should produce, from the width/alignment rules.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] rs2, input logic [31:0] rd,
                                  input int rdy, input int rsp,
                                  output rsp_t r, output bus_t b, output bit has_bus);
        int sz, off;
        bit illegal, mis;
        logic [31:0] v;
        sz  = int'(f3) % 4;
        off = int'(a % 4);
        illegal = we ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
        mis = (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
        r.fault = 0; r.cause = 0; r.rdata = 0; r.stall = 3 + rdy + rsp; r.chk_stall = 1;
        b.we = we; b.addr = a & ~32'h3; b.wdata = 0; b.wstrb = 0; b.chk_wdata = we;
        has_bus = 0;
        if (illegal) begin
            r.fault = 1; r.cause = 2; r.stall = 1;
        end else if (mis) begin
            r.fault = 1; r.cause = 1; r.stall = 1;
        end else begin
            has_bus = 1;
            if (we) begin
                case (sz)
                    0: begin b.wstrb = 4'(1 << off);           b.wdata = (rs2 & 32'hFF) * 32'h01010101; end
                    1: begin b.wstrb = 4'(3 << ((off / 2) * 2)); b.wdata = (rs2 & 32'hFFFF) * 32'h00010001; end
                    default: begin b.wstrb = 4'hF;             b.wdata = rs2; end
                endcase
            end
            if (rdy >= TO || rsp < 0) begin
                r.fault = 1; r.cause = 3; r.chk_stall = 0;
            end else if (!we) begin
                v = rd;
                if (sz == 0) begin
                    v = (rd >> (8 * off)) & 32'hFF;
                    if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFFFF00;
                end else if (sz == 1) begin
                    v = (rd >> (16 * (off / 2))) & 32'hFFFF;
                    if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF0000;
                end
                r.rdata = v;
            end
        end
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] rd,
                          input int rdy, input int rsp);
        rsp_t r;
        bus_t b;
        bit   hb, done, acc, hs_pend;
        int   vcnt, rcnt;
        model(we, f3, a, rs2, rd, rdy, rsp, r, b, hb);
        rsp_q.push_back(r);
        if (hb) bus_q.push_back(b);
        mem_req_l3 = 1; we_l3 = we; funct3_l3 = f3; alu_q_l3 = a; xrs2_l3 = rs2;
        bus_rdata = rd; bus_ready = 0; bus_rvalid = 0;
        done = 0; acc = 0; hs_pend = 0; vcnt = 0; rcnt = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            bus_rvalid = 0;
            if (hs_pend) begin acc = 1; hs_pend = 0; end
            if (!stall_l3) begin
                done = 1; bus_ready = 0;
                bus_rvalid = 1'($urandom_range(0, 1));
            end else begin
                bus_ready = 0;
                if (bus_valid) begin
                    bus_ready  = (vcnt >= rdy);
                    hs_pend    = bus_ready;
                    bus_rvalid = !bus_ready && 1'($urandom_range(0, 1));
                    vcnt++;
                end
                if (acc) begin
                    bus_rvalid = (rsp >= 0 && rcnt == rsp);
                    rcnt++;
                end
            end
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL access_hang actual=stalled required=done addr=%h", a);
        end
        @(posedge clk); #1;
        mem_req_l3 = 0; bus_ready = 0;
        bus_rvalid = 1'($urandom_range(0, 1));
    endtask

    logic prev_valid = 0;
    int   scnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
            scnt = 0;
        end else begin
            if (bus_valid) begin
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected actual=valid required=idle addr=%h", bus_addr);
                end else begin
                    chk("bus_we", bus_we, bus_q[0].we);
                    chk("bus_addr", bus_addr, bus_q[0].addr);
                    chk("bus_wstrb", bus_wstrb, bus_q[0].wstrb);
                    if (bus_q[0].chk_wdata) chk("bus_wdata", bus_wdata, bus_q[0].wdata);
                end
            end
            if (prev_valid && !bus_valid && bus_q.size() > 0) void'(bus_q.pop_front());
            prev_valid = bus_valid;

            if (mem_req_l3 && stall_l3) begin
                scnt++;
                chk("fault_outside_done", fault_l3, 0);
            end else if (mem_req_l3) begin
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp_unexpected actual=done required=none");
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("fault", fault_l3, e.fault);
                    chk("fault_cause", fault_cause_l3, e.cause);
                    chk("ram_rdata", ram_rdata_l3, e.rdata);
                    if (e.chk_stall) chk("stall_cycles", scnt, e.stall);
                end
                scnt = 0;
            end
        end
    end

    initial begin
        bus_t b;
        int   rdy, rsp;
        rst = 1; mem_req_l3 = 0; we_l3 = 0; funct3_l3 = 0; alu_q_l3 = 0; xrs2_l3 = 0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        #12;
        chk("rst_valid", bus_valid, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_rdata", ram_rdata_l3, 0);
        chk("rst_fault", {fault_l3, fault_cause_l3}, 0);
        chk("rst_stall_idle", stall_l3, 0);
        mem_req_l3 = 1; #1;
        chk("rst_stall_follows_req", stall_l3, 1);
        mem_req_l3 = 0;
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        access(0, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 0, 0);
        access(0, 3'b000, 32'h1003, 0, 32'h80FF0000, 0, 0);
        access(0, 3'b100, 32'h1003, 0, 32'h80FF0000, 0, 0);
        access(0, 3'b101, 32'h1002, 0, 32'h80FF0000, 0, 0);
        access(0, 3'b001, 32'h1002, 0, 32'h80FF0000, 1, 2);
        access(1, 3'b001, 32'h2002, 32'h1234ABCD, 0, 0, 1);
        access(1, 3'b000, 32'h2001, 32'h1234ABCD, 0, 0, 0);
        access(0, 3'b010, 32'h1001, 0, 32'h12345678, 0, 0);
        access(1, 3'b001, 32'h2003, 32'h1, 0, 0, 0);
        access(0, 3'b011, 32'h1000, 0, 0, 0, 0);
        access(1, 3'b100, 32'h1000, 0, 0, 0, 0);
        access(1, 3'b010, 32'h2000, 32'h55AA1234, 0, 3, 0);
        access(0, 3'b010, 32'h1004, 0, 32'h11111111, 1, -1);
        access(0, 3'b010, 32'h1008, 0, 32'h22222222, 9, 0);
        access(0, 3'b010, 32'h100C, 0, 32'hCAFEF00D, 0, 0);

        // Reset in the middle of a load's response wait.
        mem_req_l3 = 1; we_l3 = 0; funct3_l3 = 3'b010; alu_q_l3 = 32'h3000; xrs2_l3 = 32'h77;
        bus_ready = 1; bus_rvalid = 0;
        b.we = 0; b.addr = 32'h3000; b.wdata = 0; b.wstrb = 0; b.chk_wdata = 0;
        bus_q.push_back(b);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_ready = 0;
        chk("resp_stall", stall_l3, 1);
        rst = 1; #1;
        chk("midrst_valid", bus_valid, 0);
        chk("midrst_we_strb", {bus_we, bus_wstrb}, 0);
        chk("midrst_addr", bus_addr, 0);
        chk("midrst_wdata", bus_wdata, 0);
        chk("midrst_rdata", ram_rdata_l3, 0);
        chk("midrst_fault", {fault_l3, fault_cause_l3}, 0);
        chk("midrst_stall", stall_l3, 1);
        @(posedge clk); #1;
        rst = 0; mem_req_l3 = 0;
        bus_q.delete(); rsp_q.delete();
        @(posedge clk); #1;
        access(0, 3'b010, 32'h1000, 0, 32'hA5A5C3C3, 0, 0);

        for (int n = 0; n < 150; n++) begin
            rdy = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
            rsp = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 2));
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, $urandom, rdy, rsp);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                bus_rvalid = 0;
            end
        end

        repeat (3) @(posedge clk);
        chk("rsp_q_drained", rsp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
